// File: rtl/pc_ctrl_pkg.sv
// rtl/pc_ctrl_pkg.sv - shared states, control levels and target alignment for pc_ctrl
package pc_ctrl_pkg;

  typedef enum logic [1:0] {
    PC_S_RUN   = 2'b00,
    PC_S_HOLD  = 2'b01,
    PC_S_FLUSH = 2'b10
  } pc_state_e;

  localparam logic        FLUSH_ENABLE  = 1'b1;
  localparam logic        FLUSH_DISABLE = 1'b0;
  localparam logic        STALL_ENABLE  = 1'b1;
  localparam logic        STALL_DISABLE = 1'b0;
  localparam logic        JUMP_ENABLE   = 1'b1;
  localparam logic        HOLD_ENABLE   = 1'b1;
  localparam logic [31:0] ZERO_ADDR     = 32'h0000_0000;

  // Jump targets are forced onto a word boundary; low bits only raise misalign.
  function automatic logic [31:0] align_tgt(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/hold_wdog.sv
// rtl/hold_wdog.sv - consecutive-hold counter with sticky timeout flag
module hold_wdog
  import pc_ctrl_pkg::*;
#(
  parameter int HOLD_MAX = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic hold,
  output logic timeout
);

  localparam int CW = $clog2(HOLD_MAX + 2);
  localparam logic [CW-1:0] LIMIT = CW'(HOLD_MAX + 1);
  localparam logic [CW-1:0] LAST  = CW'(HOLD_MAX);

  logic [CW-1:0] cnt;

  // Count consecutive hold cycles (saturating) and latch timeout on reaching HOLD_MAX+1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= '0;
      timeout <= 1'b0;
    end else if (hold != HOLD_ENABLE) begin
      cnt <= '0;
    end else begin
      if (cnt != LIMIT) cnt <= cnt + 1'b1;
      if (cnt == LAST) timeout <= 1'b1;
    end
  end

endmodule

// File: rtl/pc_ctrl.sv
// rtl/pc_ctrl.sv - program counter, fetch request and pipeline stall/flush control
module pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = ZERO_ADDR,
  parameter int          FLUSH_CYCLES = 2,
  parameter int          HOLD_MAX     = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  input  logic        hold_flag_i,
  output logic [31:0] pc_o,
  output logic        inst_req_o,
  output logic        flush_o,
  output logic        stall_o,
  output logic        misalign_o,
  output logic        hold_timeout_o
);

  localparam logic [7:0] FLUSH_LOAD = 8'(FLUSH_CYCLES - 1);
  localparam pc_state_e  JUMP_STATE = (FLUSH_LOAD == 8'd0) ? PC_S_RUN : PC_S_FLUSH;

  pc_state_e   state;
  logic [7:0]  flush_cnt;
  logic        pend_valid;
  logic [31:0] pend_addr;
  logic [31:0] tgt;
  logic        jump;
  logic        hold;

  assign tgt  = align_tgt(jump_addr_i);
  assign jump = (jump_en_i == JUMP_ENABLE);
  assign hold = (hold_flag_i == HOLD_ENABLE);

  // Pipeline controls depend on the current state and this cycle's ex requests.
  always_comb begin
    flush_o = FLUSH_DISABLE;
    stall_o = STALL_DISABLE;
    case (state)
      PC_S_RUN: begin
        if (jump) flush_o = FLUSH_ENABLE;
        if (hold) stall_o = STALL_ENABLE;
      end
      PC_S_HOLD: begin
        if (hold) begin
          stall_o = STALL_ENABLE;
          if (jump) flush_o = FLUSH_ENABLE;
        end else if (pend_valid || jump) begin
          flush_o = FLUSH_ENABLE;
        end
      end
      PC_S_FLUSH: begin
        flush_o = FLUSH_ENABLE;
        if (hold) stall_o = STALL_ENABLE;
      end
      default: ;
    endcase
  end

  // FSM, PC register and pending-jump register; a jump seen at hold release is newest and wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= PC_S_RUN;
      pc_o       <= RESET_PC;
      inst_req_o <= 1'b0;
      misalign_o <= 1'b0;
      flush_cnt  <= 8'd0;
      pend_valid <= 1'b0;
      pend_addr  <= ZERO_ADDR;
    end else begin
      inst_req_o <= 1'b1;
      misalign_o <= jump && (jump_addr_i[1:0] != 2'b00);
      case (state)
        PC_S_RUN: begin
          if (jump && !hold) begin
            pc_o      <= tgt;
            flush_cnt <= FLUSH_LOAD;
            state     <= JUMP_STATE;
          end else if (hold) begin
            if (jump) begin
              pend_addr  <= tgt;
              pend_valid <= 1'b1;
            end
            state <= PC_S_HOLD;
          end else begin
            pc_o <= pc_o + 32'd4;
          end
        end
        PC_S_HOLD: begin
          if (hold) begin
            if (jump) begin
              pend_addr  <= tgt;
              pend_valid <= 1'b1;
            end
          end else if (jump || pend_valid) begin
            pc_o       <= jump ? tgt : pend_addr;
            pend_valid <= 1'b0;
            flush_cnt  <= FLUSH_LOAD;
            state      <= JUMP_STATE;
          end else begin
            pc_o  <= pc_o + 32'd4;
            state <= PC_S_RUN;
          end
        end
        PC_S_FLUSH: begin
          if (hold) begin
            if (jump) begin
              pend_addr  <= tgt;
              pend_valid <= 1'b1;
              state      <= PC_S_HOLD;
            end
          end else if (jump) begin
            pc_o      <= tgt;
            flush_cnt <= FLUSH_LOAD;
            state     <= JUMP_STATE;
          end else begin
            pc_o      <= pc_o + 32'd4;
            flush_cnt <= flush_cnt - 8'd1;
            if (flush_cnt <= 8'd1) state <= PC_S_RUN;
          end
        end
        default: state <= PC_S_RUN;
      endcase
    end
  end

  hold_wdog #(
    .HOLD_MAX(HOLD_MAX)
  ) u_hold_wdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .hold   (hold_flag_i),
    .timeout(hold_timeout_o)
  );

endmodule
